dual_issue_ctrl: RTL and testbench
==================================

# dual_issue_ctrl

Issue and hazard controller for the two-lane superscalar pipeline. Sits in ID and, each cycle, decides which of the two decoded instructions enter the ID/EX register: both, lane 1 only (split issue), the held slot-2 instruction alone, or none (bubble). It also drives PC and IF/ID hold. Lane control flags entering ID/EX are gated by `issue_1`/`issue_2`; a deasserted issue bit means a bubble (mem rd/wr and register-bank write forced to 0 by the top level).

## Interface
Parameters:
- `REG_W`, 5, register-index width
- `CNT_W`, 16, statistics counter width (used only with `DUAL_ISSUE_STATS_EN`)

Ports:
- `clk`  in  1  pipeline clock; all state changes on rising edge
- `rst_n`  in  1  synchronous reset, active-low
- `id_valid_1`, `id_valid_2`  in  1  instruction present in ID slot 1/2 (slot 1 is older)
- `id_rs_1`, `id_rt_1`, `id_rs_2`, `id_rt_2`  in  REG_W  source registers
- `id_uses_rt_1`, `id_uses_rt_2`  in  1  rt is read as a source
- `id_dest_1`, `id_dest_2`  in  REG_W  destination register
- `id_wr_1`, `id_wr_2`  in  1  register-bank write
- `id_mem_1`, `id_mem_2`  in  1  memory read or write
- `ex_dest_1`, `ex_dest_2`  in  REG_W  destination of the instruction in EX lane 1/2
- `ex_mem_rd_1`, `ex_mem_rd_2`  in  1  EX lane holds a load
- `flush`  in  1  branch/jump redirect; discard both ID slots
- `issue_1`, `issue_2`  out  1  lane enters ID/EX this cycle
- `pc_hold`, `if_id_hold`  out  1  hold PC and IF/ID contents (always equal)
- `split_pending`  out  1  state is S_SPLIT
- `stall_cnt`, `split_cnt`  out  CNT_W  statistics (only with `DUAL_ISSUE_STATS_EN`)

## Operation
- Register 0 never creates a dependency; any comparison against index 0 is false.
- `lu(k)`: valid slot k reads (rs, or rt when `id_uses_rt_k`) a nonzero register equal to `ex_dest_j` while `ex_mem_rd_j=1`, for either EX lane j.
- `dep`: both slots valid and any of: slot 2 source equals `id_dest_1` with `id_wr_1=1`; `id_mem_1 & id_mem_2` (single memory port); both write the same nonzero destination.
- States: S_PAIR (reset), S_SPLIT. Outputs are combinational from state and inputs.
- Priority, in any state: `flush` > load-use > split.
- `flush=1`: issue_1=issue_2=0, holds=0, next S_PAIR.
- S_PAIR, `lu(1)|lu(2)`: no issue, holds=1, stay S_PAIR (bubble clears hazard next cycle).
- S_PAIR, else `dep`: issue_1=1, issue_2=0, holds=1, next S_SPLIT.
- S_PAIR, otherwise: issue_k=id_valid_k, holds=0.
- S_SPLIT: slot 1 already issued; only slot 2 is evaluated. `lu(2)`: no issue, holds=1, stay S_SPLIT. Otherwise issue_1=0, issue_2=id_valid_2, holds=0, next S_PAIR.
- Slot 1 in S_SPLIT is never reissued.

## Timing
- Decision latency 0 cycles (same-cycle, Mealy); state updates at next rising edge.
- `rst_n=0` sampled at an edge: state→S_PAIR, counters→0. While `rst_n=0`: issue_1=issue_2=0, pc_hold=if_id_hold=0, split_pending=0.
- Reset mid-split: pending slot 2 is dropped; fetch restarts by the reset PC.
- Load-use then split (slot 1 load, slot 2 uses it): cycle 0 issue lane 1, cycle 1 bubble (S_SPLIT stall), cycle 2 issue slot 2; holds high cycles 0-1.
- `flush` while S_SPLIT: pending slot 2 discarded, S_PAIR next.

## Configuration
- `DUAL_ISSUE_STATS_EN` defined: `stall_cnt` +1 per cycle with holds=1 and no issue; `split_cnt` +1 per S_PAIR→S_SPLIT transition; both saturate at all-ones, clear on reset.
- Undefined: counter ports and logic absent; issue behaviour identical.

## Test plan
- Independent pair (`add r3,r1,r2` / `sub r6,r4,r5`) -> issue_1=issue_2=1, holds=0, state stays S_PAIR.
- Slot 2 reads r3 written by slot 1 -> cycle 0 issue 1/0 holds=1; cycle 1 issue 0/1 holds=0; `split_cnt`=1.
- EX lane 2 load r8, slot 1 reads r8 -> one bubble cycle, holds=1, then pair issues; `stall_cnt`=1.
- Slot 1 `lw r9`, slot 2 reads r9 -> issue 1/0, bubble, issue 0/1 over three cycles.
- `flush=1` in S_SPLIT -> issue 0/0, holds=0, next cycle S_PAIR; dest r0 on both slots -> no split.
- `rst_n=0` during S_SPLIT -> outputs 0, state S_PAIR, counters 0 after the edge.

Source files
------------

// File: rtl/dual_issue_ctrl.sv
// Two-lane ID-stage issue/hazard controller: pairs, splits or bubbles the decoded slots.
// Optional statistics counters are built when DUAL_ISSUE_STATS_EN is defined.
module dual_issue_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid_1,
    input  logic             id_valid_2,
    input  logic [REG_W-1:0] id_rs_1,
    input  logic [REG_W-1:0] id_rt_1,
    input  logic [REG_W-1:0] id_rs_2,
    input  logic [REG_W-1:0] id_rt_2,
    input  logic             id_uses_rt_1,
    input  logic             id_uses_rt_2,
    input  logic [REG_W-1:0] id_dest_1,
    input  logic [REG_W-1:0] id_dest_2,
    input  logic             id_wr_1,
    input  logic             id_wr_2,
    input  logic             id_mem_1,
    input  logic             id_mem_2,
    input  logic [REG_W-1:0] ex_dest_1,
    input  logic [REG_W-1:0] ex_dest_2,
    input  logic             ex_mem_rd_1,
    input  logic             ex_mem_rd_2,
    input  logic             flush,
    output logic             issue_1,
    output logic             issue_2,
    output logic             pc_hold,
    output logic             if_id_hold,
    output logic             split_pending
`ifdef DUAL_ISSUE_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] split_cnt
`endif
);

    typedef enum logic {S_PAIR, S_SPLIT} state_t;

    state_t state_q, state_d;
    logic   hold;
    logic   lu_1, lu_2, dep;

    // Register 0 is hard-wired, so it never matches a producer.
    function automatic logic load_hit(input logic [REG_W-1:0] r,
                                      input logic [REG_W-1:0] d1, input logic m1,
                                      input logic [REG_W-1:0] d2, input logic m2);
        return (r != '0) && ((m1 && r == d1) || (m2 && r == d2));
    endfunction

    always_comb begin
        lu_1 = id_valid_1 &&
               (load_hit(id_rs_1, ex_dest_1, ex_mem_rd_1, ex_dest_2, ex_mem_rd_2) ||
                (id_uses_rt_1 && load_hit(id_rt_1, ex_dest_1, ex_mem_rd_1, ex_dest_2, ex_mem_rd_2)));
        lu_2 = id_valid_2 &&
               (load_hit(id_rs_2, ex_dest_1, ex_mem_rd_1, ex_dest_2, ex_mem_rd_2) ||
                (id_uses_rt_2 && load_hit(id_rt_2, ex_dest_1, ex_mem_rd_1, ex_dest_2, ex_mem_rd_2)));
        dep  = id_valid_1 && id_valid_2 &&
               ((id_wr_1 && id_dest_1 != '0 &&
                 (id_rs_2 == id_dest_1 || (id_uses_rt_2 && id_rt_2 == id_dest_1))) ||
                (id_mem_1 && id_mem_2) ||
                (id_wr_1 && id_wr_2 && id_dest_1 != '0 && id_dest_1 == id_dest_2));
    end

    always_comb begin
        issue_1 = 1'b0;
        issue_2 = 1'b0;
        hold    = 1'b0;
        state_d = state_q;
        if (!rst_n || flush) begin
            state_d = S_PAIR;
        end else begin
            case (state_q)
                S_PAIR: begin
                    if (lu_1 || lu_2) begin
                        hold = 1'b1;
                    end else if (dep) begin
                        issue_1 = 1'b1;
                        hold    = 1'b1;
                        state_d = S_SPLIT;
                    end else begin
                        issue_1 = id_valid_1;
                        issue_2 = id_valid_2;
                    end
                end
                S_SPLIT: begin
                    // Slot 1 left on the previous cycle; only slot 2 remains.
                    if (lu_2) begin
                        hold = 1'b1;
                    end else begin
                        issue_2 = id_valid_2;
                        state_d = S_PAIR;
                    end
                end
                default: state_d = S_PAIR;
            endcase
        end
    end

    assign pc_hold       = hold;
    assign if_id_hold    = hold;
    assign split_pending = rst_n && (state_q == S_SPLIT);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_PAIR;
        else        state_q <= state_d;
    end

`ifdef DUAL_ISSUE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] split_cnt_q, split_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        split_cnt_d = split_cnt_q;
        if (hold && !issue_1 && !issue_2)
            stall_cnt_d = sat_inc(stall_cnt_q);
        if (state_q == S_PAIR && state_d == S_SPLIT)
            split_cnt_d = sat_inc(split_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            split_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            split_cnt_q <= split_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign split_cnt = split_cnt_q;
`else
    localparam int UNUSED_CNT_W = CNT_W;
`endif

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Self-checking bench for dual_issue_ctrl: directed test-plan scenarios plus
// randomized traffic compared against a slot/hazard-level reference model.
module tb_dual_issue_ctrl;
    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid_1, id_valid_2;
    logic [REG_W-1:0] id_rs_1, id_rt_1, id_rs_2, id_rt_2;
    logic id_uses_rt_1, id_uses_rt_2;
    logic [REG_W-1:0] id_dest_1, id_dest_2;
    logic id_wr_1, id_wr_2, id_mem_1, id_mem_2;
    logic [REG_W-1:0] ex_dest_1, ex_dest_2;
    logic ex_mem_rd_1, ex_mem_rd_2;
    logic flush;
    logic issue_1, issue_2, pc_hold, if_id_hold, split_pending;
`ifdef DUAL_ISSUE_STATS_EN
    logic [CNT_W-1:0] stall_cnt, split_cnt;
`endif

    dual_issue_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid_1(id_valid_1), .id_valid_2(id_valid_2),
        .id_rs_1(id_rs_1), .id_rt_1(id_rt_1), .id_rs_2(id_rs_2), .id_rt_2(id_rt_2),
        .id_uses_rt_1(id_uses_rt_1), .id_uses_rt_2(id_uses_rt_2),
        .id_dest_1(id_dest_1), .id_dest_2(id_dest_2),
        .id_wr_1(id_wr_1), .id_wr_2(id_wr_2), .id_mem_1(id_mem_1), .id_mem_2(id_mem_2),
        .ex_dest_1(ex_dest_1), .ex_dest_2(ex_dest_2),
        .ex_mem_rd_1(ex_mem_rd_1), .ex_mem_rd_2(ex_mem_rd_2),
        .flush(flush),
        .issue_1(issue_1), .issue_2(issue_2),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold), .split_pending(split_pending)
`ifdef DUAL_ISSUE_STATS_EN
        , .stall_cnt(stall_cnt), .split_cnt(split_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: "is a slot-2 instruction still owed from a split?" plus stat counts.
    bit m_owed;
    int m_stall, m_split;
    bit e_i1, e_i2, e_hold, e_owed_next;

    function automatic bit produced_by_load(input logic [REG_W-1:0] r);
        logic [REG_W-1:0] dst [2];
        bit ld [2];
        dst[0] = ex_dest_1; dst[1] = ex_dest_2;
        ld[0] = ex_mem_rd_1; ld[1] = ex_mem_rd_2;
        if (r == 0) return 0;
        foreach (dst[j]) if (ld[j] && dst[j] == r) return 1;
        return 0;
    endfunction

    function automatic bit waits_on_load(input int k);
        logic [REG_W-1:0] srcs[$];
        if (k == 1) begin
            if (!id_valid_1) return 0;
            srcs.push_back(id_rs_1);
            if (id_uses_rt_1) srcs.push_back(id_rt_1);
        end else begin
            if (!id_valid_2) return 0;
            srcs.push_back(id_rs_2);
            if (id_uses_rt_2) srcs.push_back(id_rt_2);
        end
        foreach (srcs[i]) if (produced_by_load(srcs[i])) return 1;
        return 0;
    endfunction

    function automatic bit cannot_pair();
        logic [REG_W-1:0] srcs2[$];
        if (!(id_valid_1 && id_valid_2)) return 0;
        if (id_mem_1 && id_mem_2) return 1;
        if (id_wr_1 && id_wr_2 && id_dest_1 != 0 && id_dest_1 == id_dest_2) return 1;
        srcs2.push_back(id_rs_2);
        if (id_uses_rt_2) srcs2.push_back(id_rt_2);
        foreach (srcs2[i]) if (id_wr_1 && id_dest_1 != 0 && srcs2[i] == id_dest_1) return 1;
        return 0;
    endfunction

    task automatic predict();
        e_i1 = 0; e_i2 = 0; e_hold = 0; e_owed_next = 0;
        if (!rst_n || flush) return;
        if (m_owed) begin
            if (waits_on_load(2)) begin e_hold = 1; e_owed_next = 1; end
            else e_i2 = id_valid_2;
        end else if (waits_on_load(1) || waits_on_load(2)) begin
            e_hold = 1;
        end else if (cannot_pair()) begin
            e_i1 = 1; e_hold = 1; e_owed_next = 1;
        end else begin
            e_i1 = id_valid_1; e_i2 = id_valid_2;
        end
    endtask

    // Inputs are set after a rising edge; compare at the falling edge, then advance the model.
    task automatic cycle(input string tag);
        int cmax;
        cmax = (1 << CNT_W) - 1;
        @(negedge clk);
        predict();
        check({tag, ".issue_1"}, {31'b0, issue_1}, {31'b0, e_i1});
        check({tag, ".issue_2"}, {31'b0, issue_2}, {31'b0, e_i2});
        check({tag, ".pc_hold"}, {31'b0, pc_hold}, {31'b0, e_hold});
        check({tag, ".if_id_hold"}, {31'b0, if_id_hold}, {31'b0, e_hold});
        check({tag, ".split_pending"}, {31'b0, split_pending}, {31'b0, rst_n && m_owed});
`ifdef DUAL_ISSUE_STATS_EN
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
        check({tag, ".split_cnt"}, 32'(split_cnt), 32'(m_split));
`endif
        @(posedge clk);
        if (!rst_n) begin
            m_owed = 0; m_stall = 0; m_split = 0;
        end else begin
            if (e_hold && !e_i1 && !e_i2 && m_stall < cmax) m_stall++;
            if (!m_owed && e_owed_next && m_split < cmax) m_split++;
            m_owed = e_owed_next;
        end
        #1;
    endtask

    task automatic clear_inputs();
        id_valid_1 = 0; id_valid_2 = 0;
        id_rs_1 = 0; id_rt_1 = 0; id_rs_2 = 0; id_rt_2 = 0;
        id_uses_rt_1 = 0; id_uses_rt_2 = 0;
        id_dest_1 = 0; id_dest_2 = 0;
        id_wr_1 = 0; id_wr_2 = 0; id_mem_1 = 0; id_mem_2 = 0;
        ex_dest_1 = 0; ex_dest_2 = 0; ex_mem_rd_1 = 0; ex_mem_rd_2 = 0;
        flush = 0;
    endtask

    task automatic slot1(input int rs, input int rt, input int dst, input bit mem);
        id_valid_1 = 1; id_rs_1 = REG_W'(rs); id_rt_1 = REG_W'(rt); id_uses_rt_1 = 1;
        id_dest_1 = REG_W'(dst); id_wr_1 = 1; id_mem_1 = mem;
    endtask

    task automatic slot2(input int rs, input int rt, input int dst, input bit mem);
        id_valid_2 = 1; id_rs_2 = REG_W'(rs); id_rt_2 = REG_W'(rt); id_uses_rt_2 = 1;
        id_dest_2 = REG_W'(dst); id_wr_2 = 1; id_mem_2 = mem;
    endtask

    task automatic do_reset();
        rst_n = 0;
        cycle("reset0");
        cycle("reset1");
        rst_n = 1;
    endtask

    initial begin
        clear_inputs();
        m_owed = 0; m_stall = 0; m_split = 0;
        rst_n = 0;
        #1;
        do_reset();

        // add r3,r1,r2 / sub r6,r4,r5
        slot1(1, 2, 3, 0); slot2(4, 5, 6, 0);
        cycle("indep");
        check("indep.const_i2", {31'b0, issue_2}, 32'd1);

        // slot 2 reads r3 produced by slot 1
        slot1(1, 2, 3, 0); slot2(3, 5, 6, 0);
        cycle("raw.c0");
        check("raw.c0.const_split", {31'b0, split_pending}, 32'd1);
        cycle("raw.c1");
        clear_inputs();

        // EX lane 2 loads r8, slot 1 reads r8
        slot1(8, 2, 3, 0); slot2(4, 5, 6, 0);
        ex_dest_2 = 8; ex_mem_rd_2 = 1;
        cycle("lu.c0");
        ex_mem_rd_2 = 0;
        cycle("lu.c1");
        clear_inputs();

        // lw r9 in slot 1, slot 2 uses r9: split, bubble, issue
        slot1(1, 0, 9, 1); id_uses_rt_1 = 0; slot2(9, 4, 6, 0);
        cycle("lwsplit.c0");
        ex_dest_1 = 9; ex_mem_rd_1 = 1;
        cycle("lwsplit.c1");
        ex_mem_rd_1 = 0;
        cycle("lwsplit.c2");
        clear_inputs();

        // flush while a slot 2 is owed
        slot1(1, 2, 3, 0); slot2(3, 5, 6, 0);
        cycle("flush.c0");
        flush = 1;
        cycle("flush.c1");
        flush = 0; clear_inputs();
        cycle("flush.c2");

        // both write r0: never a dependency
        slot1(0, 0, 0, 0); slot2(0, 0, 0, 0);
        cycle("r0");

        // reset during a split
        slot1(1, 2, 3, 0); slot2(3, 5, 6, 0);
        cycle("rstsplit.c0");
        rst_n = 0;
        cycle("rstsplit.c1");
        rst_n = 1; clear_inputs();
        cycle("rstsplit.c2");

        // randomized traffic over a small register range to provoke hazards
        for (int n = 0; n < 600; n++) begin
            rst_n        = ($urandom_range(0, 99) != 0);
            flush        = ($urandom_range(0, 9) == 0);
            id_valid_1   = ($urandom_range(0, 9) != 0);
            id_valid_2   = ($urandom_range(0, 9) != 0);
            id_rs_1      = REG_W'($urandom_range(0, 4));
            id_rt_1      = REG_W'($urandom_range(0, 4));
            id_rs_2      = REG_W'($urandom_range(0, 4));
            id_rt_2      = REG_W'($urandom_range(0, 4));
            id_uses_rt_1 = 1'($urandom);
            id_uses_rt_2 = 1'($urandom);
            id_dest_1    = REG_W'($urandom_range(0, 4));
            id_dest_2    = REG_W'($urandom_range(0, 4));
            id_wr_1      = 1'($urandom);
            id_wr_2      = 1'($urandom);
            id_mem_1     = ($urandom_range(0, 3) == 0);
            id_mem_2     = ($urandom_range(0, 3) == 0);
            ex_dest_1    = REG_W'($urandom_range(0, 4));
            ex_dest_2    = REG_W'($urandom_range(0, 4));
            ex_mem_rd_1  = ($urandom_range(0, 3) == 0);
            ex_mem_rd_2  = ($urandom_range(0, 3) == 0);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
